// File: rtl/core_pkg.sv
// Shared encodings for the integer execute path: ALU opcodes, condition codes
// and the bit positions of the N/Z/C/V flags inside a 4-bit nzcv vector.
package core_pkg;

  typedef enum logic [4:0] {
    ALU_PLUS   = 5'd0,
    ALU_MINUS  = 5'd1,
    ALU_ORN    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_EOR    = 5'd4,
    ALU_AND    = 5'd5,
    ALU_MOV    = 5'd6,
    ALU_LSL    = 5'd7,
    ALU_LSR    = 5'd8,
    ALU_ASR    = 5'd9,
    ALU_PASS_A = 5'd10,
    ALU_UBFM   = 5'd11,
    ALU_SBFM   = 5'd12,
    ALU_CSEL   = 5'd13,
    ALU_CSINV  = 5'd14,
    ALU_CSINC  = 5'd15,
    ALU_CSNEG  = 5'd16
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a condition field against an nzcv flag vector.
module cond_eval
  import core_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       holds
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  assign n_s = nzcv[FLAG_N];
  assign z_s = nzcv[FLAG_Z];
  assign c_s = nzcv[FLAG_C];
  assign v_s = nzcv[FLAG_V];

  // Decode the condition field against the supplied flags
  always_comb begin
    holds = 1'b1;
    case (cond)
      COND_EQ: holds = z_s;
      COND_NE: holds = ~z_s;
      COND_CS: holds = c_s;
      COND_CC: holds = ~c_s;
      COND_MI: holds = n_s;
      COND_PL: holds = ~n_s;
      COND_VS: holds = v_s;
      COND_VC: holds = ~v_s;
      COND_HI: holds = c_s & ~z_s;
      COND_LS: holds = ~(c_s & ~z_s);
      COND_GE: holds = (n_s == v_s);
      COND_LT: holds = (n_s != v_s);
      COND_GT: holds = ~z_s & (n_s == v_s);
      COND_LE: holds = ~(~z_s & (n_s == v_s));
      COND_AL: holds = 1'b1;
      COND_NV: holds = 1'b1;
      default: holds = 1'b1;
    endcase
  end

endmodule

// File: rtl/arith_exec_pipe.sv
// Integer execute unit: single-cycle ALU/bitfield/conditional-select compute
// feeding a STAGES-deep valid/ready register pipeline with flush.
module arith_exec_pipe
  import core_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic              in_set_cc,
  input  logic [WIDTH-1:0]  in_vala,
  input  logic [WIDTH-1:0]  in_valb,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [5:0]        in_hw,
  input  logic [5:0]        in_imms,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_nzcv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_res,
  output logic [3:0]        out_nzcv,
  output logic              out_cond_val,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int LW = $clog2(WIDTH);
  localparam int PW = WIDTH + 5 + TAG_W;
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LW:0]      ONE_L = {{LW{1'b0}}, 1'b1};

  // Low n bits set; n == WIDTH yields all ones.
  function automatic logic [WIDTH-1:0] low_mask(input logic [LW:0] n);
    if (int'(n) >= WIDTH) begin
      low_mask = {WIDTH{1'b1}};
    end else begin
      low_mask = (ONE_W << n) - ONE_W;
    end
  endfunction

  logic [LW-1:0]    shamt_s;
  logic [LW-1:0]    hw_s;
  logic [LW-1:0]    immr_s;
  logic [LW-1:0]    imms_s;
  logic             cond_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] diff_s;
  logic             add_ovf_s;
  logic             sub_ovf_s;
  logic [LW-1:0]    bf_top_s;
  logic [WIDTH-1:0] ubfm_s;
  logic [WIDTH-1:0] sbfm_s;
  logic [WIDTH-1:0] res_s;
  logic             flag_c_s;
  logic             flag_v_s;
  logic [3:0]       nzcv_s;

  assign shamt_s = in_valb[LW-1:0];
  assign hw_s    = in_hw[LW-1:0];
  assign immr_s  = in_hw[LW-1:0];
  assign imms_s  = in_imms[LW-1:0];

  cond_eval u_cond_eval (
    .cond  (in_cond),
    .nzcv  (in_nzcv),
    .holds (cond_s)
  );

  assign sum_s     = {1'b0, in_vala} + {1'b0, in_valb};
  assign diff_s    = in_vala - in_valb;
  assign add_ovf_s = (in_vala[WIDTH-1] == in_valb[WIDTH-1]) && (sum_s[WIDTH-1] != in_vala[WIDTH-1]);
  assign sub_ovf_s = (in_vala[WIDTH-1] != in_valb[WIDTH-1]) && (diff_s[WIDTH-1] != in_vala[WIDTH-1]);

  // Bitfield move: the top of the placed field is imms-immr modulo WIDTH in both forms
  always_comb begin
    bf_top_s = imms_s - immr_s;
    if (imms_s >= immr_s) begin
      ubfm_s = (in_vala >> immr_s) & low_mask({1'b0, bf_top_s} + ONE_L);
    end else begin
      ubfm_s = (in_vala & low_mask({1'b0, imms_s} + ONE_L)) << ({LW{1'b0}} - immr_s);
    end
    if (in_vala[imms_s]) begin
      sbfm_s = ubfm_s | ~low_mask({1'b0, bf_top_s} + ONE_L);
    end else begin
      sbfm_s = ubfm_s;
    end
  end

  // Result selection plus carry/overflow for the arithmetic ops
  always_comb begin
    res_s    = {WIDTH{1'b0}};
    flag_c_s = 1'b0;
    flag_v_s = 1'b0;
    case (in_op)
      ALU_PLUS: begin
        res_s    = sum_s[WIDTH-1:0];
        flag_c_s = sum_s[WIDTH];
        flag_v_s = add_ovf_s;
      end
      ALU_MINUS: begin
        res_s    = diff_s;
        flag_c_s = (in_vala >= in_valb);
        flag_v_s = sub_ovf_s;
      end
      ALU_ORN:    res_s = in_vala | ~in_valb;
      ALU_OR:     res_s = in_vala | in_valb;
      ALU_EOR:    res_s = in_vala ^ in_valb;
      ALU_AND:    res_s = in_vala & in_valb;
      ALU_MOV:    res_s = in_vala | (in_valb << hw_s);
      ALU_LSL:    res_s = in_vala << shamt_s;
      ALU_LSR:    res_s = in_vala >> shamt_s;
      ALU_ASR:    res_s = $unsigned($signed(in_vala) >>> shamt_s);
      ALU_PASS_A: res_s = in_vala;
      ALU_UBFM:   res_s = ubfm_s;
      ALU_SBFM:   res_s = sbfm_s;
      ALU_CSEL:   res_s = cond_s ? in_vala : in_valb;
      ALU_CSINV:  res_s = cond_s ? in_vala : ~in_valb;
      ALU_CSINC:  res_s = cond_s ? in_vala : (in_valb + ONE_W);
      ALU_CSNEG:  res_s = cond_s ? in_vala : ({WIDTH{1'b0}} - in_valb);
      default:    res_s = {WIDTH{1'b0}};
    endcase
  end

  // Flags are recomputed only when requested, otherwise passed through
  always_comb begin
    nzcv_s = in_nzcv;
    if (in_set_cc) begin
      nzcv_s[FLAG_N] = res_s[WIDTH-1];
      nzcv_s[FLAG_Z] = (res_s == {WIDTH{1'b0}});
      nzcv_s[FLAG_C] = flag_c_s;
      nzcv_s[FLAG_V] = flag_v_s;
    end else begin
      nzcv_s = in_nzcv;
    end
  end

  logic [PW-1:0]     comp_pay_s;
  logic [STAGES-1:0] stg_v_s;
  logic [PW-1:0]     stg_pay_s [STAGES];
  logic [STAGES-1:0] take_s;
  logic              accept_s;

  assign comp_pay_s = {res_s, nzcv_s, cond_s, in_tag};
  assign in_ready   = ~rst & take_s[0];
  assign accept_s   = in_valid & in_ready;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic          v_in_s;
    logic [PW-1:0] pay_in_s;
    logic          v_r;
    logic [PW-1:0] pay_r;

    if (g == 0) begin : g_head
      assign v_in_s   = accept_s;
      assign pay_in_s = comp_pay_s;
    end else begin : g_body
      assign v_in_s   = stg_v_s[g-1];
      assign pay_in_s = stg_pay_s[g-1];
    end

    // A stage can take new data unless it and every stage after it are full and the sink stalls
    assign take_s[g] = out_ready | ~(&stg_v_s[STAGES-1:g]);

    // Stage register: cleared by reset, emptied by flush, loaded when there is room
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r   <= 1'b0;
        pay_r <= {PW{1'b0}};
      end else if (flush) begin
        v_r <= 1'b0;
      end else if (take_s[g]) begin
        v_r <= v_in_s;
        if (v_in_s) begin
          pay_r <= pay_in_s;
        end
      end
    end

    assign stg_v_s[g]   = v_r;
    assign stg_pay_s[g] = pay_r;
  end

  assign out_valid = stg_v_s[STAGES-1];
  assign {out_res, out_nzcv, out_cond_val, out_tag} = stg_pay_s[STAGES-1];

endmodule
